// File: rtl/ik_arbiter.sv
// ik_arbiter: round-robin sharing of one inverse-kinematics solver between two
// requesters. Holds the granted point on the solver inputs, ignores the solver's
// stale valid during a settle window, waits for a fresh result (with timeout)
// and returns the angles tagged with the requester id.
`timescale 1ns/1ps
module ik_arbiter #(
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 200000,
  parameter int CNT_W       = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  output logic        req1_ready,
  output logic [31:0] ik_x,
  output logic [31:0] ik_y,
  input  logic        ik_valid,
  input  logic [31:0] ik_xita1,
  input  logic [31:0] ik_xita2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_xita1,
  output logic [31:0] rsp_xita2,
  output logic        rsp_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_grant_q;
  logic [31:0]      ik_x_q;
  logic [31:0]      ik_y_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [31:0]      rsp_xita1_q;
  logic [31:0]      rsp_xita2_q;
  logic             rsp_timeout_q;
  logic             gnt0;
  logic             gnt1;

  assign cnt_d = cnt_q + CNT_W'(1);

  // Grant decision: sole valid requester wins, a tie goes to the one not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  // Job sequencer: accept, settle, wait for fresh result or timeout, hold response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      ik_x_q        <= '0;
      ik_y_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_xita1_q   <= '0;
      rsp_xita2_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt0 || gnt1) begin
            ik_x_q       <= gnt1 ? req1_x : req0_x;
            ik_y_q       <= gnt1 ? req1_y : req0_y;
            rsp_id_q     <= gnt1;
            last_grant_q <= gnt1;
            cnt_q        <= '0;
            state_q      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // The solver still shows the previous point's valid here; ignore it.
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT: begin
          // A result on the last allowed cycle still beats the timeout.
          if (ik_valid) begin
            rsp_xita1_q   <= ik_xita1;
            rsp_xita2_q   <= ik_xita2;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else if (cnt_q == TIMEOUT_LAST) begin
            rsp_xita1_q   <= '0;
            rsp_xita2_q   <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign ik_x        = ik_x_q;
  assign ik_y        = ik_y_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_xita1   = rsp_xita1_q;
  assign rsp_xita2   = rsp_xita2_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ik_arbiter.sv
// Bench for ik_arbiter: job-level reference model (round-robin grant, expected
// response latency, payload) driven by randomized requests and a solver model.
`timescale 1ns/1ps
module tb_ik_arbiter;

  localparam int SETTLE = 2;
  localparam int TMO    = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_x = '0;
  logic [31:0] req0_y = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_x = '0;
  logic [31:0] req1_y = '0;
  logic        req1_ready;
  logic [31:0] ik_x;
  logic [31:0] ik_y;
  logic        ik_valid = 1'b0;
  logic [31:0] ik_xita1 = '0;
  logic [31:0] ik_xita2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [31:0] rsp_xita1;
  logic [31:0] rsp_xita2;
  logic        rsp_timeout;
  logic        busy;

  int checks = 0;
  int failures = 0;

  // Reference model state: who was served last and which points are pending.
  bit          m_last;
  bit          pend0, pend1;
  logic [31:0] px0, py0, px1, py1;

  always #5 clk = ~clk;

  ik_arbiter #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO), .CNT_W(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
    .ik_x(ik_x), .ik_y(ik_y), .ik_valid(ik_valid), .ik_xita1(ik_xita1), .ik_xita2(ik_xita2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_xita1(rsp_xita1), .rsp_xita2(rsp_xita2), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    ik_valid = 1'b0;
    pend0 = 1'b0;
    pend1 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_last = 1'b1;
    check_eq("rst_ik", {ik_x, ik_y}, 96'd0);
    check_eq("rst_rsp", {rsp_xita1, rsp_xita2}, 96'd0);
    check_eq("rst_flags", {rsp_valid, rsp_id, rsp_timeout, busy, req0_ready, req1_ready}, 96'd0);
    $display("reset done");
  endtask

  // One job: add requests, predict grant, run solver model (lat<=0 = never answers),
  // predict response latency and payload, apply hold cycles of backpressure.
  task automatic do_job(input bit add0, input bit add1,
                        input logic [31:0] x0, input logic [31:0] y0,
                        input logic [31:0] x1, input logic [31:0] y1,
                        input int lat, input logic [31:0] a1, input logic [31:0] a2,
                        input int hold);
    bit g;
    int k;
    int e;
    logic [31:0] gx, gy, ea1, ea2;
    if (add0 && !pend0) begin pend0 = 1'b1; px0 = x0; py0 = y0; end
    if (add1 && !pend1) begin pend1 = 1'b1; px1 = x1; py1 = y1; end
    req0_valid = pend0; req0_x = px0; req0_y = py0;
    req1_valid = pend1; req1_x = px1; req1_y = py1;
    g  = (pend0 && pend1) ? ~m_last : pend1;
    gx = g ? px1 : px0;
    gy = g ? py1 : py0;
    #1;
    check_eq("ready", {req0_ready, req1_ready, busy}, {~g, g, 1'b0});
    @(posedge clk);
    #1;
    m_last = g;
    if (g) begin pend1 = 1'b0; req1_valid = 1'b0; end
    else   begin pend0 = 1'b0; req0_valid = 1'b0; end
    check_eq("accept", {ik_x, ik_y, busy, req0_ready, req1_ready}, {gx, gy, 3'b100});
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) ik_valid = 1'b0;
      if (lat > 0 && k == lat) begin
        ik_valid = 1'b1;
        ik_xita1 = a1;
        ik_xita2 = a2;
      end
    end while (!rsp_valid && k < 400);
    e   = (lat > 0) ? ((lat + 1 > SETTLE + 1) ? lat + 1 : SETTLE + 1) : SETTLE + TMO;
    ea1 = (lat > 0) ? a1 : 32'd0;
    ea2 = (lat > 0) ? a2 : 32'd0;
    check_eq("latency", k, e);
    check_eq("rsp", {rsp_valid, rsp_id, rsp_timeout, rsp_xita1, rsp_xita2},
             {1'b1, g, (lat <= 0), ea1, ea2});
    check_eq("hold_xy", {ik_x, ik_y}, {gx, gy});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq("backpressure",
               {rsp_valid, rsp_id, rsp_timeout, rsp_xita1, rsp_xita2, busy, req0_ready, req1_ready},
               {1'b1, g, (lat <= 0), ea1, ea2, 3'b100});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_eq("handshake", {rsp_valid, busy}, 2'b00);
    $display("job id=%0d x=%08h y=%08h lat=%0d cycles=%0d timeout=%0d xita1=%08h xita2=%08h",
             g, gx, gy, lat, k, (lat <= 0), ea1, ea2);
  endtask

  // Job from req0 interrupted by reset in WAIT or RESP, then a tie must go to req0.
  task automatic mid_reset(input bit in_resp);
    pend1 = 1'b0; req1_valid = 1'b0;
    px0 = $urandom; py0 = $urandom;
    req0_valid = 1'b1; req0_x = px0; req0_y = py0;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    ik_valid = 1'b0;
    if (in_resp) begin
      ik_valid = 1'b1;
      ik_xita1 = $urandom;
      ik_xita2 = $urandom;
      repeat (4) @(posedge clk);
      #1;
      check_eq("pre_rst_resp", {busy, rsp_valid}, 2'b11);
    end else begin
      repeat (5) @(posedge clk);
      #1;
      check_eq("pre_rst_wait", {busy, rsp_valid}, 2'b10);
    end
    do_reset();
    do_job(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 20, $urandom, $urandom, 0);
    do_job(1'b0, 1'b0, 0, 0, 0, 0, 15, $urandom, $urandom, 0);
  endtask

  initial begin
    bit a0, a1;
    int lat;
    do_reset();

    // Single job with fixed point and angles.
    do_job(1'b1, 1'b0, 32'h000A_0000, 32'h0005_0000, 0, 0, 50, 32'h002D_0000, 32'h003C_0000, 0);

    // Ties after reset alternate, starting with req0.
    do_reset();
    do_job(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 10, $urandom, $urandom, 0);
    do_job(1'b0, 1'b0, 0, 0, 0, 0, 5, $urandom, $urandom, 0);
    do_job(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 3, $urandom, $urandom, 0);
    do_job(1'b0, 1'b0, 0, 0, 0, 0, 2, $urandom, $urandom, 0);

    // Timeout, then a normal job.
    do_job(1'b0, 1'b1, 0, 0, $urandom, $urandom, 0, 0, 0, 0);
    do_job(1'b1, 1'b0, $urandom, $urandom, 0, 0, 30, $urandom, $urandom, 0);

    // Stale valid with old angles held while the new point is accepted.
    ik_valid = 1'b1;
    ik_xita1 = 32'h0010_0000;
    ik_xita2 = 32'h0010_0000;
    do_job(1'b1, 1'b0, $urandom, $urandom, 0, 0, 10, 32'h0020_0000, 32'h0020_0000, 0);

    // Backpressure with the other requester waiting.
    do_job(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 12, $urandom, $urandom, 10);
    do_job(1'b0, 1'b0, 0, 0, 0, 0, 4, $urandom, $urandom, 0);

    // Randomized jobs.
    for (int n = 0; n < 24; n++) begin
      a0 = 1'($urandom_range(0, 1));
      a1 = 1'($urandom_range(0, 1));
      if (!pend0 && !pend1 && !a0 && !a1) a0 = 1'b1;
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 60));
      do_job(a0, a1, $urandom, $urandom, $urandom, $urandom, lat, $urandom, $urandom,
             int'($urandom_range(0, 5)));
    end

    mid_reset(1'b0);
    mid_reset(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
